imm_decode_pipe: RTL and testbench
==================================

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32, 64.
REQ-002 SHALL have parameter NB, default XLEN/8, byte-lane count; derived, never overridden.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have port in_valid, input, 1, idata valid.
REQ-007 SHALL have port in_ready, output, 1, stage can accept idata.
REQ-008 SHALL have port idata, input, 32, instruction word.
REQ-009 SHALL have port out_valid, output, 1, decoded entry available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts entry.
REQ-011 SHALL have port imm, output, XLEN, signed, sign-extended immediate.
REQ-012 SHALL have port we, output, NB, store byte-enable mask (unshifted, lane 0 based).
REQ-013 SHALL have port wer, output, 1, register-file write enable.
REQ-014 SHALL have port illegal, output, 1, unsupported opcode/funct3 flag.
REQ-015 SHALL have port illegal_cnt, output, 16, saturating illegal-instruction count.

Function
REQ-016 SHALL decode idata[6:0]: R 0110011 -> wer=1, imm=0; I 0010011, L 0000011, JALR 1100111 -> imm=sext(idata[31:20]), wer=1; S 0100011 -> imm=sext({idata[31:25],idata[11:7]}), wer=0; B 1100011 -> imm=sext({idata[31],idata[7],idata[30:25],idata[11:8],0}), wer=0; JAL 1101111 -> imm=sext({idata[31],idata[19:12],idata[20],idata[30:21],0}), wer=1; LUI 0110111, AUIPC 0010111 -> imm=sext({idata[31:12],12'b0}), wer=1.
REQ-017 SHALL sign-extend every immediate from bit 31 of the constructed value to XLEN (LUI/AUIPC included).
REQ-018 SHALL set we=0 for every non-store; for stores, funct3 000 -> lower 1 lane, 001 -> lower 2, 010 -> lower 4, 011 -> all 8 lanes only when XLEN=64.
REQ-019 SHALL treat any unlisted opcode, store funct3 not covered by REQ-018, as undecodable: imm=0, we=0, wer=0 (never hold previous values).
REQ-020 SHALL register decode results; an entry accepted in cycle N appears on outputs with out_valid=1 in cycle N+1 when the output register is empty or draining.
REQ-021 SHALL accept an entry when in_valid && in_ready; out entry retires when out_valid && out_ready.
REQ-022 SHALL contain one output register plus one skid register; in_ready SHALL be a register output, equal to !skid_valid.
REQ-023 SHALL load an accepted entry into the skid register when the output register holds an entry and out_ready=0; in_ready falls the following cycle.
REQ-024 SHALL move the skid entry into the output register on retirement, in order, and raise in_ready the following cycle; no entry is ever dropped or duplicated.
REQ-025 SHALL keep output fields stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on flush=1, clear out_valid and skid_valid next cycle, ignore same-cycle input, and set in_ready=1; flush has priority over accept and retire.
REQ-027 SHALL drive imm, we, wer, illegal to 0 whenever out_valid=0.

Reset
REQ-028 SHALL on rst_n=0 immediately clear out_valid, skid_valid, imm, we, wer, illegal, illegal_cnt and set in_ready=1, regardless of clock.
REQ-029 SHALL discard any in-flight entry on reset mid-transfer; first accept possible on first clk edge with rst_n=1.

Configuration
REQ-030 SHALL compile illegal detection only when macro DECODE_ILLEGAL_EN is defined.
REQ-031 With DECODE_ILLEGAL_EN: illegal=1 for entries matching REQ-019; illegal_cnt increments by 1 per retired illegal entry, saturating at 0xFFFF, unaffected by flush.
REQ-032 Without DECODE_ILLEGAL_EN: illegal and illegal_cnt tied to 0; REQ-019 decode still applies.

Verification
REQ-033 SHALL cover: idata=0xFFF00093 (addi -1), out_ready=1 -> next cycle imm=0xFFFFFFFF, wer=1, we=0, out_valid=1.
REQ-034 SHALL cover: XLEN=64, sd idata=0x00B53023 -> we=0xFF, wer=0, imm=0; XLEN=32 same word -> we=0, illegal=1 (macro on).
REQ-035 SHALL cover: out_ready=0, two back-to-back accepts (lui 0x12345037, jal 0x0000006F) -> in_ready=0 after second; raising out_ready yields imm=0x12345000 then imm=0, in order.
REQ-036 SHALL cover: both registers full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.
REQ-037 SHALL cover: 0x10000 retired illegal words (idata=0x00000000) with macro on -> illegal_cnt=0xFFFF; macro off -> 0.
REQ-038 SHALL cover: rst_n low between edges while skid full -> outputs zero immediately, in_ready=1.

Source files
------------

// File: rtl/imm_decode_pipe_if.sv
// Handshake and result bundle for the immediate decode pipe.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, idata (instruction word in); out_valid, out_ready, imm, we,
//        wer, illegal, illegal_cnt (decoded entry out).
// master = producer/consumer side, slave = the decode pipe itself.
interface imm_decode_pipe_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            idata;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [XLEN-1:0] imm;
  logic [NB-1:0]          we;
  logic                   wer;
  logic                   illegal;
  logic [15:0]            illegal_cnt;

  modport master (
    output in_valid, idata, out_ready,
    input  in_ready, out_valid, imm, we, wer, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, idata, out_ready,
    output in_ready, out_valid, imm, we, wer, illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_decode_pipe.sv
// Immediate / byte-enable / write-enable decode for RV32/RV64 instruction words.
// Latency: 1 cycle from accept to out_valid (output register, plus one skid entry).
// Backpressure: in_ready is registered (= !skid_valid); one extra entry absorbed while out_ready=0.
// Ports: clk, rst_n (async active-low), flush (sync discard), bus (imm_decode_pipe_if.slave).
// Optional feature: define DECODE_ILLEGAL_EN to build the illegal flag and saturating
// illegal_cnt; otherwise both are tied to 0 (undecodable words still decode to all-zero).
module imm_decode_pipe #(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_decode_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [NB-1:0]   we;
    logic            wer;
`ifdef DECODE_ILLEGAL_EN
    logic            ill;
`endif
  } ent_t;

  // ---------------- combinational decode ----------------
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm32;
  logic [NB-1:0] we_d;
  logic        wer_d;
  logic        bad_d;
  ent_t        d_ent;

  always_comb begin
    op    = bus.idata[6:0];
    f3    = bus.idata[14:12];
    imm32 = '0;
    we_d  = '0;
    wer_d = 1'b0;
    bad_d = 1'b0;
    case (op)
      7'b0110011: wer_d = 1'b1;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm32 = {{20{bus.idata[31]}}, bus.idata[31:20]};
        wer_d = 1'b1;
      end
      7'b0100011: begin
        imm32 = {{20{bus.idata[31]}}, bus.idata[31:25], bus.idata[11:7]};
        case (f3)
          3'b000:  we_d = NB'(1);
          3'b001:  we_d = NB'(3);
          3'b010:  we_d = NB'(15);
          3'b011: begin
            // doubleword stores only exist with an 8-lane datapath
            if (NB == 8) we_d = '1;
            else         bad_d = 1'b1;
          end
          default: bad_d = 1'b1;
        endcase
        // an undecodable store must not leak its offset
        if (bad_d) imm32 = '0;
      end
      7'b1100011:
        imm32 = {{19{bus.idata[31]}}, bus.idata[31], bus.idata[7],
                 bus.idata[30:25], bus.idata[11:8], 1'b0};
      7'b1101111: begin
        imm32 = {{11{bus.idata[31]}}, bus.idata[31], bus.idata[19:12],
                 bus.idata[20], bus.idata[30:21], 1'b0};
        wer_d = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        imm32 = {bus.idata[31:12], 12'b0};
        wer_d = 1'b1;
      end
      default: bad_d = 1'b1;
    endcase

    d_ent     = '0;
    // bit 31 of the constructed value is the sign, for U-type too
    d_ent.imm = XLEN'(signed'(imm32));
    d_ent.we  = we_d;
    d_ent.wer = wer_d;
`ifdef DECODE_ILLEGAL_EN
    d_ent.ill = bad_d;
`endif
  end

  // ---------------- output register + skid register ----------------
  logic out_vld;
  logic skid_vld;
  ent_t out_q;
  ent_t skid_q;
  logic accept;
  logic retire;

  assign accept = bus.in_valid && !skid_vld;
  assign retire = out_vld && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!out_vld || bus.out_ready) begin
      // output register free or draining: the older skid entry goes first
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_q   <= d_ent;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= d_ent;
      skid_vld <= 1'b1;
    end
  end

  assign bus.in_ready  = !skid_vld;
  assign bus.out_valid = out_vld;
  assign bus.imm       = out_vld ? out_q.imm : '0;
  assign bus.we        = out_vld ? out_q.we  : '0;
  assign bus.wer       = out_vld & out_q.wer;

`ifdef DECODE_ILLEGAL_EN
  logic [15:0] cnt_q;

  // flush wins over retire, so a flushed entry is never counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (!flush && retire && out_q.ill && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign bus.illegal     = out_vld & out_q.ill;
  assign bus.illegal_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire   = retire;
  assign bus.illegal     = 1'b0;
  assign bus.illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
// Checks a hand-written vector table, directed skid/flush/reset sequences, random
// traffic against a queue-based reference model, and illegal counter saturation.
module tb_imm_decode_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] idata;

  imm_decode_pipe_if #(.XLEN(32)) b32();
  imm_decode_pipe_if #(.XLEN(64)) b64();

  assign b32.in_valid  = in_valid;
  assign b32.idata     = idata;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.idata     = idata;
  assign b64.out_ready = out_ready;

  imm_decode_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));
  imm_decode_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave));

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_ON = 1'b1;
`else
  localparam bit ILL_ON = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [7:0]  we64;
    logic [3:0]  we32;
    logic        wer;
    logic        ill32;
    logic        ill64;
  } exp_t;

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    longint signed x, top;
    int lanes;
    e   = '0;
    x   = longint'(signed'(w));
    top = (x < 0) ? -1 : 0;
    case (w[6:0])
      7'h33: e.wer = 1'b1;
      7'h13, 7'h03, 7'h67: begin e.imm64 = x >>> 20; e.wer = 1'b1; end
      7'h23: begin
        if (w[14:12] <= 3'd3) begin
          lanes   = 1 << w[14:12];
          e.imm64 = (x >>> 25) * 32 + longint'(w[11:7]);
          e.we64  = 8'((1 << lanes) - 1);
          if (lanes <= 4) e.we32 = 4'((1 << lanes) - 1);
          else e.ill32 = 1'b1;
        end else begin
          e.ill32 = 1'b1;
          e.ill64 = 1'b1;
        end
      end
      7'h63: e.imm64 = top * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                       + longint'(w[11:8]) * 2;
      7'h6F: begin
        e.imm64 = top * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                  + longint'(w[30:21]) * 2;
        e.wer = 1'b1;
      end
      7'h37, 7'h17: begin e.imm64 = (x >>> 12) * 4096; e.wer = 1'b1; end
      default: begin e.ill32 = 1'b1; e.ill64 = 1'b1; end
    endcase
    e.imm32 = e.ill32 ? 32'h0 : e.imm64[31:0];
    return e;
  endfunction

  exp_t q[$];
  int   cnt32 = 0;
  int   cnt64 = 0;

  task automatic model_reset();
    q.delete();
    cnt32 = 0;
    cnt64 = 0;
  endtask

  task automatic compare_all();
    exp_t e;
    bit   ov;
    ov = (q.size() > 0);
    e  = ov ? q[0] : '0;
    chk("out_valid32", b32.out_valid, ov);
    chk("in_ready32", b32.in_ready, q.size() < 2);
    chk("imm32", {32'h0, b32.imm}, {32'h0, e.imm32});
    chk("we32", b32.we, e.we32);
    chk("wer32", b32.wer, e.wer);
    chk("illegal32", b32.illegal, ILL_ON & e.ill32);
    chk("illegal_cnt32", b32.illegal_cnt, ILL_ON ? cnt32 : 0);
    chk("out_valid64", b64.out_valid, ov);
    chk("in_ready64", b64.in_ready, q.size() < 2);
    chk("imm64", b64.imm, e.imm64);
    chk("we64", b64.we, e.we64);
    chk("wer64", b64.wer, e.wer);
    chk("illegal64", b64.illegal, ILL_ON & e.ill64);
    chk("illegal_cnt64", b64.illegal_cnt, ILL_ON ? cnt64 : 0);
  endtask

  // One clock: predict accept/retire from the pre-edge state, then compare #1 after the edge.
  task automatic step();
    bit   acc, ret;
    exp_t e;
    acc = in_valid && (q.size() < 2);
    ret = (q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (ret) begin
        e = q.pop_front();
        if (e.ill32 && cnt32 < 65535) cnt32++;
        if (e.ill64 && cnt64 < 65535) cnt64++;
      end
      if (acc) q.push_back(ref_decode(idata));
    end
    compare_all();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [3:0]  we32;
    logic [7:0]  we64;
    logic        wer;
    logic        ill32;
    logic        ill64;
  } vec_t;

  vec_t tbl[15];
  logic [6:0] ops[10];

  initial begin
    logic [15:0] cnt_before32, cnt_before64;
    logic [31:0] r;

    tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{32'h00B53023, 32'h00000000, 64'h00000000_00000000, 4'h0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32'h12345037, 32'h12345000, 64'h00000000_12345000, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000006F, 32'h00000000, 64'h00000000_00000000, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{32'h80000037, 32'h80000000, 64'hFFFFFFFF_80000000, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{32'h00A12223, 32'h00000004, 64'h00000000_00000004, 4'hF, 8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'hFE000FA3, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 4'h1, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h8000006F, 32'hFFF00000, 64'hFFFFFFFF_FFF00000, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{32'h00B50533, 32'h00000000, 64'h00000000_00000000, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{32'h00000000, 32'h00000000, 64'h00000000_00000000, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{32'h00004023, 32'h00000000, 64'h00000000_00000000, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{32'h800080E7, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{32'h00452503, 32'h00000004, 64'h00000000_00000004, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};

    // ---- reset state ----
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; idata = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- table: one word at a time, consumer always ready ----
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; idata = tbl[i].w; out_ready = 1'b1;
      step();
      chk($sformatf("tbl%0d_valid", i), b32.out_valid & b64.out_valid, 1'b1);
      chk($sformatf("tbl%0d_imm32", i), {32'h0, b32.imm}, {32'h0, tbl[i].imm32});
      chk($sformatf("tbl%0d_imm64", i), b64.imm, tbl[i].imm64);
      chk($sformatf("tbl%0d_we32", i), b32.we, tbl[i].we32);
      chk($sformatf("tbl%0d_we64", i), b64.we, tbl[i].we64);
      chk($sformatf("tbl%0d_wer", i), {b32.wer, b64.wer}, {tbl[i].wer, tbl[i].wer});
      chk($sformatf("tbl%0d_ill", i), {b32.illegal, b64.illegal},
          {ILL_ON & tbl[i].ill32, ILL_ON & tbl[i].ill64});
    end
    in_valid = 1'b0;
    step();

    // ---- two back-to-back accepts into a stalled output, then drain in order ----
    out_ready = 1'b0; in_valid = 1'b1; idata = 32'h12345037;
    step();
    idata = 32'h0000006F;
    step();
    in_valid = 1'b0;
    chk("b2b_in_ready_low", {b32.in_ready, b64.in_ready}, 2'b00);
    chk("b2b_first_imm", {32'h0, b32.imm}, 64'h12345000);
    step();
    chk("b2b_hold_imm", b64.imm, 64'h12345000);
    out_ready = 1'b1;
    step();
    chk("b2b_second_imm", b64.imm, 64'h0);
    chk("b2b_second_wer", b32.wer, 1'b1);
    chk("b2b_in_ready_back", b32.in_ready, 1'b1);
    step();
    chk("b2b_drained", b32.out_valid | b64.out_valid, 1'b0);

    // ---- flush with both registers full and a same-cycle input ----
    out_ready = 1'b0; in_valid = 1'b1; idata = 32'h00000000;
    step();
    step();
    cnt_before32 = b32.illegal_cnt;
    cnt_before64 = b64.illegal_cnt;
    flush = 1'b1; idata = 32'h12345037;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {b32.out_valid, b64.out_valid}, 2'b00);
    chk("flush_in_ready", {b32.in_ready, b64.in_ready}, 2'b11);
    chk("flush_cnt32", b32.illegal_cnt, cnt_before32);
    chk("flush_cnt64", b64.illegal_cnt, cnt_before64);
    chk("flush_imm_zero", b64.imm, 64'h0);
    step();

    // ---- async reset between edges with the skid register full ----
    in_valid = 1'b1; idata = 32'hFFF00093;
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_skid_full", b32.in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", {b32.out_valid, b64.out_valid}, 2'b00);
    chk("rst_in_ready", {b32.in_ready, b64.in_ready}, 2'b11);
    chk("rst_imm", b64.imm, 64'h0);
    chk("rst_wer", {b32.wer, b64.wer}, 2'b00);
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // ---- random traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      r = $urandom();
      if ($urandom_range(0, 7) == 0) idata = r;
      else idata = {r[31:7], ops[$urandom_range(0, 9)]};
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    // ---- illegal counter saturation ----
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; idata = 32'h00000000;
    repeat (65536 + 6) step();
    in_valid = 1'b0;
    step();
    chk("sat_cnt32", b32.illegal_cnt, ILL_ON ? 16'hFFFF : 16'h0);
    chk("sat_cnt64", b64.illegal_cnt, ILL_ON ? 16'hFFFF : 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
